// File: rtl/nn_cfg_pkg.sv
// Shared definitions for the neuron configuration loader: FSM encoding, word width
// and the helper that pulls one 32-bit field out of a packed parameter vector.
package nn_cfg_pkg;

    localparam int CFG_WORD_WIDTH = 32;
    // Upper bound on packed fields; parameter vectors are zero-extended to this size.
    localparam int MAX_FIELDS     = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_CHK    = 3'd3,
        ST_DONE   = 3'd4
    } cfg_state_t;

    function automatic logic [CFG_WORD_WIDTH-1:0] field32(
        input logic [CFG_WORD_WIDTH*MAX_FIELDS-1:0] vec,
        input int                                   idx
    );
        return vec[CFG_WORD_WIDTH*idx +: CFG_WORD_WIDTH];
    endfunction

endpackage

// File: rtl/nn_config_loader.sv
// Streams flat weight/bias words onto the shared neuron configuration bus, tagging each
// with its (layer, neuron). Optional trailing checksum word enabled by NN_CFG_CHECKSUM_EN.
module nn_config_loader
    import nn_cfg_pkg::*;
#(
    parameter int                        NUM_LAYERS    = 3,
    parameter logic [32*NUM_LAYERS-1:0]  LAYER_INPUTS  = {32'd10, 32'd30, 32'd30},
    parameter logic [32*NUM_LAYERS-1:0]  LAYER_NEURONS = {32'd1, 32'd10, 32'd30},
    parameter int                        CNT_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CFG_WORD_WIDTH-1:0] s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [CFG_WORD_WIDTH-1:0] weightValue,
    output logic [CFG_WORD_WIDTH-1:0] biasValue,
    output logic                      weightValid,
    output logic                      biasValid,
    output logic [CFG_WORD_WIDTH-1:0] config_layer_num,
    output logic [CFG_WORD_WIDTH-1:0] config_neuron_num,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam logic [CFG_WORD_WIDTH*MAX_FIELDS-1:0] INPUTS_EXT  = (CFG_WORD_WIDTH*MAX_FIELDS)'(LAYER_INPUTS);
    localparam logic [CFG_WORD_WIDTH*MAX_FIELDS-1:0] NEURONS_EXT = (CFG_WORD_WIDTH*MAX_FIELDS)'(LAYER_NEURONS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] LAST_LAYER = CNT_WIDTH'(NUM_LAYERS - 1);

    cfg_state_t state_reg, state_next;

    logic [CNT_WIDTH-1:0] w_cnt_reg, n_cnt_reg, l_cnt_reg;
    logic [CNT_WIDTH-1:0] inputs_lim  [NUM_LAYERS];
    logic [CNT_WIDTH-1:0] neurons_lim [NUM_LAYERS];
    logic [CNT_WIDTH-1:0] cur_inputs, cur_neurons;
    logic                 last_w, last_n, last_l, accept;

    logic [CFG_WORD_WIDTH-1:0] weight_value_reg, bias_value_reg;
    logic [CFG_WORD_WIDTH-1:0] layer_num_reg, neuron_num_reg;
    logic                      weight_valid_reg, bias_valid_reg;

    // Per-layer limits truncated to counter width once, then muxed by the layer counter.
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_lim
        assign inputs_lim[gi]  = CNT_WIDTH'(field32(INPUTS_EXT, gi));
        assign neurons_lim[gi] = CNT_WIDTH'(field32(NEURONS_EXT, gi));
    end

    always_comb begin
        cur_inputs  = '0;
        cur_neurons = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (l_cnt_reg == CNT_WIDTH'(i)) begin
                cur_inputs  = inputs_lim[i];
                cur_neurons = neurons_lim[i];
            end
        end
    end

    assign accept = s_valid & s_ready;
    assign last_w = (w_cnt_reg == cur_inputs - CNT_ONE);
    assign last_n = (n_cnt_reg == cur_neurons - CNT_ONE);
    assign last_l = (l_cnt_reg == LAST_LAYER);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_LOAD_W;
            ST_LOAD_W: if (accept && last_w) state_next = ST_LOAD_B;
            ST_LOAD_B: begin
                if (accept) begin
                    if (last_n && last_l) begin
`ifdef NN_CFG_CHECKSUM_EN
                        state_next = ST_CHK;
`else
                        state_next = ST_DONE;
`endif
                    end else begin
                        state_next = ST_LOAD_W;
                    end
                end
            end
            ST_CHK:    if (accept) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state_reg == ST_LOAD_W) || (state_reg == ST_LOAD_B) || (state_reg == ST_CHK);
        busy    = (state_reg != ST_IDLE);
        done    = (state_reg == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_cnt_reg <= '0;
            n_cnt_reg <= '0;
            l_cnt_reg <= '0;
        end else if (state_reg == ST_IDLE && start) begin
            w_cnt_reg <= '0;
            n_cnt_reg <= '0;
            l_cnt_reg <= '0;
        end else if (accept && state_reg == ST_LOAD_W) begin
            w_cnt_reg <= last_w ? '0 : w_cnt_reg + CNT_ONE;
        end else if (accept && state_reg == ST_LOAD_B) begin
            if (!last_n) begin
                n_cnt_reg <= n_cnt_reg + CNT_ONE;
            end else if (!last_l) begin
                n_cnt_reg <= '0;
                l_cnt_reg <= l_cnt_reg + CNT_ONE;
            end
        end
    end

    // Bus registers: valids pulse per accept, data and indices hold until the next accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weight_valid_reg <= 1'b0;
            bias_valid_reg   <= 1'b0;
            weight_value_reg <= '0;
            bias_value_reg   <= '0;
            layer_num_reg    <= '0;
            neuron_num_reg   <= '0;
        end else begin
            weight_valid_reg <= accept && (state_reg == ST_LOAD_W);
            bias_valid_reg   <= accept && (state_reg == ST_LOAD_B);
            if (accept && (state_reg == ST_LOAD_W || state_reg == ST_LOAD_B)) begin
                layer_num_reg  <= CFG_WORD_WIDTH'(l_cnt_reg);
                neuron_num_reg <= CFG_WORD_WIDTH'(n_cnt_reg);
                if (state_reg == ST_LOAD_W) weight_value_reg <= s_data;
                else                        bias_value_reg   <= s_data;
            end
        end
    end

    assign weightValid       = weight_valid_reg;
    assign biasValid         = bias_valid_reg;
    assign weightValue       = weight_value_reg;
    assign biasValue         = bias_value_reg;
    assign config_layer_num  = layer_num_reg;
    assign config_neuron_num = neuron_num_reg;

`ifdef NN_CFG_CHECKSUM_EN
    logic [CFG_WORD_WIDTH-1:0] sum_reg;
    logic                      error_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_reg   <= '0;
            error_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && start) begin
            sum_reg   <= '0;
            error_reg <= 1'b0;
        end else if (accept && (state_reg == ST_LOAD_W || state_reg == ST_LOAD_B)) begin
            sum_reg <= sum_reg + s_data;
        end else if (accept && state_reg == ST_CHK) begin
            error_reg <= (s_data != sum_reg);
        end
    end

    assign error = error_reg;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_nn_config_loader.sv
// Randomized and directed bench for nn_config_loader against a word-indexed reference model.
module tb_nn_config_loader;

`ifdef NN_CFG_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    localparam int NL = 2;
    int p_in  [NL] = '{3, 2};
    int p_neu [NL] = '{2, 1};

    logic        clk = 1'b0;
    logic        rst, start, s_valid, s_ready;
    logic [31:0] s_data;
    logic [31:0] weightValue, biasValue, config_layer_num, config_neuron_num;
    logic        weightValid, biasValid, busy, done, error;

    nn_config_loader #(
        .NUM_LAYERS   (NL),
        .LAYER_INPUTS ({32'd2, 32'd3}),
        .LAYER_NEURONS({32'd1, 32'd2}),
        .CNT_WIDTH    (16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .weightValue(weightValue), .biasValue(biasValue),
        .weightValid(weightValid), .biasValid(biasValid),
        .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // Expected tag per word of a pass, derived from the layer/neuron/input nesting.
    int t_bias [64];
    int t_l    [64];
    int t_n    [64];
    int total = 0;

    initial begin
        for (int l = 0; l < NL; l++)
            for (int n = 0; n < p_neu[l]; n++)
                for (int w = 0; w <= p_in[l]; w++) begin
                    t_bias[total] = (w == p_in[l]) ? 1 : 0;
                    t_l[total]    = l;
                    t_n[total]    = n;
                    total++;
                end
    end

    // Reference model: phase 0 idle, 1 loading, 2 done pulse.
    int          phase, idx;
    logic [31:0] m_wval, m_bval, m_layer, m_neuron, m_sum;
    logic        m_wv, m_bv, m_err;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= 0; idx <= 0; m_wval <= 0; m_bval <= 0; m_layer <= 0; m_neuron <= 0;
            m_sum <= 0; m_wv <= 0; m_bv <= 0; m_err <= 0;
        end else begin
            m_wv <= 1'b0;
            m_bv <= 1'b0;
            if (phase == 2) begin
                phase <= 0;
            end else if (phase == 0) begin
                if (start) begin
                    phase <= 1; idx <= 0; m_sum <= 0; m_err <= 0;
                end
            end else if (s_valid) begin
                if (idx < total) begin
                    if (t_bias[idx] != 0) begin m_bv <= 1'b1; m_bval <= s_data; end
                    else                  begin m_wv <= 1'b1; m_wval <= s_data; end
                    m_layer  <= 32'(t_l[idx]);
                    m_neuron <= 32'(t_n[idx]);
                    m_sum    <= m_sum + s_data;
                    idx      <= idx + 1;
                    if (idx + 1 == total && !CHK_EN) phase <= 2;
                end else begin
                    m_err <= (s_data != m_sum);
                    phase <= 2;
                end
            end
        end
    end

    typedef struct {
        logic [31:0] val;
        logic        bias;
        logic [31:0] l;
        logic [31:0] n;
    } ev_t;
    ev_t log_q[$];
    bit  cmp_en = 1'b0;
    bit  log_en = 1'b0;
    int  done_cnt = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("s_ready", s_ready, phase == 1);
            check("busy", busy, phase != 0);
            check("done", done, phase == 2);
            check("weightValid", weightValid, m_wv);
            check("biasValid", biasValid, m_bv);
            check("weightValue", weightValue, m_wval);
            check("biasValue", biasValue, m_bval);
            check("layer_num", config_layer_num, m_layer);
            check("neuron_num", config_neuron_num, m_neuron);
            check("error", error, m_err);
            check("valid_exclusive", weightValid & biasValid, 0);
            if (done) done_cnt++;
            if (log_en && (weightValid || biasValid))
                log_q.push_back('{weightValid ? weightValue : biasValue, biasValid,
                                  config_layer_num, config_neuron_num});
        end
    end

    logic [31:0] wq [$];

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: back-to-back, 1: valid on one cycle in three, 2: random valid.
    task automatic stream(input int from, input int upto, input int mode);
        int   k   = from;
        int   cyc = 0;
        logic acc;
        while (k < upto && cyc < 2000) begin
            s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom % 2);
            s_data  = wq[k];
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) k++;
            cyc++;
        end
        s_valid = 1'b0;
        check("stream_timeout", k, upto);
    endtask

    task automatic fill_std(input logic [31:0] chk_word);
        wq.delete();
        for (int i = 1; i <= 11; i++) wq.push_back(32'(i));
        if (CHK_EN) wq.push_back(chk_word);
    endtask

    int lit_bias [11] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1};
    int lit_l    [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    int lit_n    [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0};

    task automatic log_check(input string tag);
        check({tag, "_log_len"}, log_q.size(), 11);
        for (int i = 0; i < 11 && i < log_q.size(); i++) begin
            check({tag, "_val"},  log_q[i].val, 32'(i + 1));
            check({tag, "_kind"}, log_q[i].bias, lit_bias[i]);
            check({tag, "_l"},    log_q[i].l, lit_l[i]);
            check({tag, "_n"},    log_q[i].n, lit_n[i]);
        end
        $display("pass %s: %0d bus words logged, done pulses=%0d", tag, log_q.size(), done_cnt);
    endtask

    task automatic full_pass(input string tag, input int mode);
        log_q.delete(); done_cnt = 0; log_en = 1'b1;
        fill_std(32'd66);
        pulse_start();
        stream(0, wq.size(), mode);
        idle(3);
        log_en = 1'b0;
        log_check(tag);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        logic [31:0] s;
        rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check("total_words", total, 11);
        check("reset_busy", busy, 0);
        check("reset_ready", s_ready, 0);
        idle(1);
        rst = 1'b1;
        idle(2);

        full_pass("back2back", 0);
        full_pass("toggle", 1);

        // start pulsed mid-pass must not restart the indices
        log_q.delete(); done_cnt = 0; log_en = 1'b1;
        fill_std(32'd66);
        pulse_start();
        stream(0, 5, 0);
        pulse_start();
        stream(5, wq.size(), 0);
        idle(3);
        log_en = 1'b0;
        log_check("restart_ignored");
        check("restart_done_cnt", done_cnt, 1);

        // reset mid-pass
        fill_std(32'd66);
        pulse_start();
        stream(0, 6, 0);
        idle(1);
        #2 rst = 1'b0;
        #1;
        check("rst_weightValid", weightValid, 0);
        check("rst_biasValid", biasValid, 0);
        check("rst_weightValue", weightValue, 0);
        check("rst_biasValue", biasValue, 0);
        check("rst_layer", config_layer_num, 0);
        check("rst_neuron", config_neuron_num, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", s_ready, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);
        full_pass("after_reset", 0);

        if (CHK_EN) begin
            check("chk_good_error", error, 0);
            fill_std(32'd65);
            pulse_start();
            stream(0, wq.size(), 0);
            idle(3);
            check("chk_bad_error", error, 1);
            idle(4);
            check("chk_sticky", error, 1);
            pulse_start();
            check("chk_cleared", error, 0);
            fill_std(32'd66);
            stream(0, wq.size(), 2);
            idle(3);
            check("chk_regood", error, 0);
        end

        for (int p = 0; p < 4; p++) begin
            wq.delete(); s = 0;
            for (int i = 0; i < total; i++) begin
                wq.push_back($urandom);
                s = s + wq[i];
            end
            if (CHK_EN) wq.push_back(s + 32'($urandom % 2));
            done_cnt = 0;
            pulse_start();
            stream(0, wq.size(), 2);
            idle(3);
            check("rand_done_cnt", done_cnt, 1);
            $display("random pass %0d: words=%0d done pulses=%0d error=%0b", p, wq.size(), done_cnt, error);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nn_config_loader.md
Name: nn_config_loader

Overview:
- Sequences the weight/bias programming bus shared by every neuron in the network.
- Consumes one flat 32-bit stream of parameters on a valid/ready input and drives the shared configuration bus: weightValid, biasValid, weightValue, biasValue, config_layer_num, config_neuron_num.
- Each word is steered to the correct (layer, neuron) by tagging it with layer/neuron indices.
- Sits between the host/DMA interface and the layer arrays; used only in non-pretrained builds.

Parameters:
- NUM_LAYERS, 3: number of layers to program.
- LAYER_INPUTS, {32'd10,32'd30,32'd30}: packed 32-bit fields; field L (bits 32*L+:32) is the weights-per-neuron of layer L.
- LAYER_NEURONS, {32'd1,32'd10,32'd30}: packed 32-bit fields; field L is the neuron count of layer L.
- CNT_WIDTH, 16: width of the internal weight and neuron counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a full programming pass.
- s_data  in  32  parameter stream word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts a word this cycle.
- weightValue  out  32  weight word to neurons.
- biasValue  out  32  bias word to neurons.
- weightValid  out  1  weightValue is valid for the addressed neuron.
- biasValid  out  1  biasValue is valid for the addressed neuron.
- config_layer_num  out  32  target layer index.
- config_neuron_num  out  32  target neuron index.
- busy  out  1  a programming pass is in progress.
- done  out  1  one-cycle pulse when the pass completes.
- error  out  1  sticky checksum failure (feature only; otherwise tied 0).

Behaviour:
- Reset values: rst low forces all outputs to 0 and the FSM to IDLE.
  - This applies mid-pass: the partial load is abandoned and no further valids are issued.
- Accept rule: a word is accepted on a cycle where s_valid & s_ready.
- FSM states:
  - IDLE: s_ready=0, busy=0. On start, clear layer/neuron/weight counters and go to LOAD_W.
  - LOAD_W: s_ready=1. Each accepted word is a weight; w_cnt increments. The accept with w_cnt==LAYER_INPUTS[L]-1 clears w_cnt and goes to LOAD_B.
  - LOAD_B: s_ready=1. The accepted word is the bias. Then:
    - if neuron<LAYER_NEURONS[L]-1: neuron++, go to LOAD_W;
    - else if L<NUM_LAYERS-1: L++, neuron=0, go to LOAD_W;
    - else go to DONE (or CHK when the feature is enabled).
  - DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Output latency: outputs are registered, one cycle after the accept.
  - weightValid/biasValid pulse for one cycle.
  - config_layer_num and config_neuron_num hold the indices of the accepted word on that same cycle.
  - Indices stay stable until the next accept.
  - weightValid and biasValid are never both high.
- Stall: with s_valid low, no valids are issued and the counters hold. Gaps between words are unlimited.
- start is ignored while busy=1.
- busy=1 from the cycle after start through DONE.
- Indices are zero-extended to 32 bits. All comparisons use CNT_WIDTH counters against parameter fields truncated to CNT_WIDTH.
- Word count per pass = sum over L of LAYER_NEURONS[L]*(LAYER_INPUTS[L]+1).

Optional Feature:
- Macro: NN_CFG_CHECKSUM_EN.
- With it defined:
  - A 32-bit wrapping sum accumulates every accepted weight/bias word.
  - After the final bias the FSM enters CHK (s_ready=1) and accepts one extra word, with no valids issued.
  - Mismatch sets error, which is sticky until the next start or reset.
  - done pulses in either case.
- Without it: no CHK state, no trailing word, error tied 0.

Decomposition:
- Shared package nn_cfg_pkg holds:
  - FSM state encoding (IDLE, LOAD_W, LOAD_B, CHK, DONE);
  - CFG_WORD_WIDTH=32;
  - function field32(vec, idx) extracting a packed 32-bit parameter field.
- No sub-module: a single FSM with counters is the natural size.

Test Plan (NUM_LAYERS=2, LAYER_INPUTS={2,3}, LAYER_NEURONS={1,2}, i.e. L0: 3 inputs, 2 neurons; L1: 2 inputs, 1 neuron):
- Back-to-back stream of 11 words 1..11 after start:
  - weightValid for words 1-3 with (0,0);
  - biasValid for word 4 with (0,0);
  - weights 5-7 and bias 8 with (0,1);
  - weights 9-10 and bias 11 with (1,0);
  - done pulses once, busy drops.
- s_valid toggled 1,0,0,1 repeatedly: the same tag sequence as above, and no valid is ever issued in a stall cycle.
- start pulsed again after word 5: ignored, and the indices continue at (0,1).
- Reset asserted after word 6: all outputs 0 immediately. A new start followed by words 1..11 reproduces the first test exactly.
- NN_CFG_CHECKSUM_EN with 11 words plus trailing checksum 66: error=0, done=1. Repeating with trailing 65: error=1, sticky until the next start.
- Each accepted word appears on the bus exactly one cycle after its accept. weightValid and biasValid are never asserted together (assertion).
